trigger_in_decoder: RTL

// - Receive side of the trigger pulse protocol: measures width of an incoming active-low trigger pulse
//   and decodes it back to the 2-bit pulse-rate code (1/2/5/10 ms at 27 MHz).
// - Sits between an external trigger pin and the UART/report logic; emits one-cycle valid or error strobes.
// - Rejects glitches, out-of-window widths and stuck-active inputs.

---
 rtl/trigger_pkg.sv | 23 ++
 rtl/trigger_in_decoder_if.sv | 26 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/trigger_in_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Constants and rate codes shared by the transmit and receive ends of the trigger pulse link.
package trigger_pkg;

    typedef enum logic [1:0] {
        RATE1 = 2'b00,
        RATE2 = 2'b01,
        RATE3 = 2'b10,
        RATE4 = 2'b11
    } rate_e;

    localparam int PULSE_CNT_W     = 25;
    localparam int PULSE_WIDTH_1   = 27000;
    localparam int PULSE_WIDTH_2   = 54000;
    localparam int PULSE_WIDTH_3   = 135000;
    localparam int PULSE_WIDTH_4   = 270000;
    localparam int PULSE_TOL       = 2700;
    localparam int PULSE_MAX_COUNT = 300000;

    function automatic logic in_window(input int count, input int nominal, input int tol);
        return (count >= nominal - tol) && (count <= nominal + tol);
    endfunction

endpackage

// File: rtl/trigger_in_decoder_if.sv
// Trigger pin and decoded-rate report bundle between the pin side and the report logic.
interface trigger_in_decoder_if;

    logic       trig_in;
    logic [1:0] rate_out;
    logic       rate_valid;
    logic       rate_error;
    logic       busy;

    modport slave (
        input  trig_in,
        output rate_out,
        output rate_valid,
        output rate_error,
        output busy
    );

    modport master (
        output trig_in,
        input  rate_out,
        input  rate_valid,
        input  rate_error,
        input  busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset level is a parameter
// so the output can come out of reset at the line's idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic n_reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Synchronizer chain
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/trigger_in_decoder.sv
// Measures the width of an active-low trigger pulse and decodes it to a 2-bit rate code,
// rejecting glitches, off-window widths and stuck-active inputs.
module trigger_in_decoder
    import trigger_pkg::*;
#(
    parameter int CNT_W     = PULSE_CNT_W,
    parameter int WIDTH_1   = PULSE_WIDTH_1,
    parameter int WIDTH_2   = PULSE_WIDTH_2,
    parameter int WIDTH_3   = PULSE_WIDTH_3,
    parameter int WIDTH_4   = PULSE_WIDTH_4,
    parameter int TOL       = PULSE_TOL,
    parameter int MAX_COUNT = PULSE_MAX_COUNT
) (
    input  logic                 clock,
    input  logic                 n_reset,
    trigger_in_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_MEASURE      = 2'd1,
        ST_CLASSIFY     = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_CNT_C = CNT_W'(MAX_COUNT);

    if (WIDTH_1 <= TOL) begin : g_bad_tol
        $error("trigger_in_decoder: WIDTH_1 must exceed TOL");
    end
    if ((WIDTH_1 + TOL >= WIDTH_2 - TOL) || (WIDTH_2 + TOL >= WIDTH_3 - TOL) ||
        (WIDTH_3 + TOL >= WIDTH_4 - TOL)) begin : g_bad_overlap
        $error("trigger_in_decoder: width windows overlap");
    end
    if (MAX_COUNT <= WIDTH_4 + TOL) begin : g_bad_max
        $error("trigger_in_decoder: MAX_COUNT must exceed WIDTH_4+TOL");
    end
    if (64'(MAX_COUNT) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("trigger_in_decoder: MAX_COUNT does not fit in CNT_W bits");
    end

    logic             sync_s;
    logic             act_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc_s;
    logic [1:0]       flush_q, flush_d;
    logic             armed_q, armed_d;
    logic [1:0]       rate_q, rate_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;
    logic [2:0]       class_s;

    // First matching window wins; bit 2 flags a hit
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] count);
        int c;
        c = int'(count);
        if (in_window(c, WIDTH_1, TOL)) begin
            classify = {1'b1, RATE1};
        end else if (in_window(c, WIDTH_2, TOL)) begin
            classify = {1'b1, RATE2};
        end else if (in_window(c, WIDTH_3, TOL)) begin
            classify = {1'b1, RATE3};
        end else if (in_window(c, WIDTH_4, TOL)) begin
            classify = {1'b1, RATE4};
        end else begin
            classify = 3'b000;
        end
    endfunction

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_trig (
        .clock   (clock),
        .n_reset (n_reset),
        .d_i     (bus.trig_in),
        .q_o     (sync_s)
    );

    assign act_s       = ~sync_s;
    assign count_inc_s = count_q + ONE_C;
    assign class_s     = classify(count_q);

    // Arm only once the flushed synchronizer shows the line idle, so a pulse in progress at reset release is skipped
    always_comb begin
        flush_d = {flush_q[0], 1'b1};
        armed_d = armed_q | (flush_q[1] & ~act_s);
    end

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rate_d  = rate_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && act_s) begin
                    count_d = ONE_C;
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (act_s) begin
                    count_d = count_inc_s;
                    if (count_inc_s == MAX_CNT_C) begin
                        error_d = 1'b1;
                        state_d = ST_WAIT_RELEASE;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else begin
                    state_d = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (class_s[2]) begin
                    rate_d  = class_s[1:0];
                    valid_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_WAIT_RELEASE: begin
                if (!act_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            flush_q <= 2'b00;
            armed_q <= 1'b0;
            rate_q  <= 2'b00;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            flush_q <= flush_d;
            armed_q <= armed_d;
            rate_q  <= rate_d;
            valid_q <= valid_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rate_out   = rate_q;
    assign bus.rate_valid = valid_q;
    assign bus.rate_error = error_q;
    assign bus.busy       = busy_q;

endmodule
